spi_rr_arbiter: RTL and testbench

SPI_RR_ARBITER -- requirements
Module: spi_rr_arbiter

---
 rtl/spi_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_spi_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter that shares one SPI master between N_REQ requesters.
// Optional WAIT-state timeout abort is built when SPI_TIMEOUT_EN is defined.
module spi_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] mode_in,
    input  logic [8*N_REQ-1:0] din_in,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               m_start,
    output logic [1:0]         m_mode,
    output logic [7:0]         m_din,
    input  logic               m_done,
    output logic               busy,
    output logic               err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic [PTR_W-1:0]   cur, cur_n;
    logic [N_REQ-1:0]   gnt_n, done_n;
    logic               m_start_n, busy_n;
    logic [1:0]         mode_n;
    logic [7:0]         din_n;
    logic               fin;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (i == PTR_W'(N_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // First set request bit at or after p, wrapping modulo N_REQ.
    function automatic logic [PTR_W-1:0] pick(input logic [N_REQ-1:0] r,
                                              input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] win;
        logic             found;
        idx   = p;
        win   = p;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return win;
    endfunction

`ifdef SPI_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             err_n;
    logic             tmo;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cur_n     = cur;
        gnt_n     = gnt;
        done_n    = '0;
        m_start_n = 1'b0;
        mode_n    = m_mode;
        din_n     = m_din;
        fin       = 1'b0;
`ifdef SPI_TIMEOUT_EN
        cnt_n     = cnt;
        err_n     = 1'b0;
        tmo       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    cur_n        = pick(req, ptr);
                    gnt_n        = '0;
                    gnt_n[cur_n] = 1'b1;
                    mode_n       = mode_in[{cur_n, 1'b0} +: 2];
                    din_n        = din_in[{cur_n, 3'b000} +: 8];
                    state_n      = LOAD;
                end
            end
            LOAD: state_n = START;
            START: begin
                m_start_n = 1'b1;
                state_n   = WAIT;
`ifdef SPI_TIMEOUT_EN
                cnt_n     = '0;
`endif
            end
            WAIT: begin
                fin = m_done;
`ifdef SPI_TIMEOUT_EN
                tmo   = !m_done && (cnt == CNT_W'(TIMEOUT - 1));
                cnt_n = cnt + 1'b1;
                err_n = tmo;
                fin   = m_done | tmo;
`endif
                if (fin) begin
                    done_n  = gnt;
                    gnt_n   = '0;
                    ptr_n   = next_idx(cur);
                    state_n = FINISH;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cur     <= '0;
            gnt     <= '0;
            done    <= '0;
            m_start <= 1'b0;
            m_mode  <= 2'b00;
            m_din   <= 8'h00;
            busy    <= 1'b0;
`ifdef SPI_TIMEOUT_EN
            cnt     <= '0;
            err     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cur     <= cur_n;
            gnt     <= gnt_n;
            done    <= done_n;
            m_start <= m_start_n;
            m_mode  <= mode_n;
            m_din   <= din_n;
            busy    <= busy_n;
`ifdef SPI_TIMEOUT_EN
            cnt     <= cnt_n;
            err     <= err_n;
`endif
        end
    end

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// Directed scoreboard bench for spi_rr_arbiter (N_REQ=4); the timeout case
// is exercised when SPI_TIMEOUT_EN is defined, the hold-forever case otherwise.
module tb_spi_rr_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [2*N-1:0] mode_in;
    logic [8*N-1:0] din_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           m_start;
    logic [1:0]     m_mode;
    logic [7:0]     m_din;
    logic           m_done;
    logic           busy;
    logic           err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         k;
        logic [7:0] din;
        logic [1:0] mode;
    } exp_t;
    exp_t sb[$];

    spi_rr_arbiter #(.N_REQ(N), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .mode_in(mode_in), .din_in(din_in),
        .gnt(gnt), .done(done), .m_start(m_start), .m_mode(m_mode),
        .m_din(m_din), .m_done(m_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k);
        exp_t e;
        e.k    = k;
        e.din  = din_in[8*k +: 8];
        e.mode = mode_in[2*k +: 2];
        sb.push_back(e);
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!m_start && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // One granted transfer: start pulse, hold of captured data, done pulse, idle gap.
    task automatic xfer(input int lat, input bit drop, input int exp_lat);
        exp_t e;
        int   cyc;
        wait_start(cyc);
        chk("start_seen", m_start, 1);
        if (exp_lat >= 0) chk("start_latency", cyc, exp_lat);
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.k = 0; e.din = 8'hxx; e.mode = 2'bxx;
        end
        chk("gnt", gnt, onehot(e.k));
        chk("m_din", m_din, e.din);
        chk("m_mode", m_mode, e.mode);
        chk("busy_wait", busy, 1);
        @(negedge clk);
        chk("m_start_single", m_start, 0);
        if (drop) req[e.k] = 1'b0;
        din_in  = ~din_in;
        mode_in = ~mode_in;
        @(negedge clk);
        chk("m_din_hold", m_din, e.din);
        chk("m_mode_hold", m_mode, e.mode);
        chk("gnt_hold", gnt, onehot(e.k));
        din_in  = ~din_in;
        mode_in = ~mode_in;
        repeat (lat - 3) @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        chk("done_pulse", done, onehot(e.k));
        chk("gnt_clear", gnt, 0);
        chk("err_low", err, 0);
        chk("busy_finish", busy, 1);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("busy_idle_gap", busy, 0);
    endtask

    initial begin
        int cyc;
        rst     = 1'b1;
        req     = '0;
        m_done  = 1'b0;
        din_in  = {8'h3C, 8'h5A, 8'h96, 8'hA5};
        mode_in = {2'b00, 2'b11, 2'b01, 2'b10};
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_m_mode", m_mode, 0);
        chk("rst_m_din", m_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single requester 0, long master latency
        req = 4'b0001;
        push(0);
        xfer(20, 0, 3);
        req = 4'b0000;
        @(negedge clk);

        // Pointer now 1: requester 1 ahead of 0
        req = 4'b0011;
        push(1); push(0);
        xfer(4, 0, 3);
        xfer(5, 0, 3);
        req = 4'b0000;

        // Reset back to ptr 0, then all requesting
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        push(0); push(1); push(2); push(3); push(0);
        xfer(3, 0, 3);
        xfer(4, 0, 3);
        xfer(6, 0, 3);
        xfer(3, 0, 3);
        xfer(7, 0, 3);
        req = 4'b0000;

        // Wrap: bring ptr to 3 via requester 2, then 3 and 0 together
        req = 4'b0100;
        push(2);
        xfer(4, 0, 3);
        req = 4'b1001;
        push(3); push(0);
        xfer(5, 0, 3);
        xfer(4, 0, 3);
        req = 4'b0000;

        // Spurious m_done in IDLE, LOAD and START; req dropped in WAIT
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        chk("spur_idle_busy", busy, 0);
        chk("spur_idle_gnt", gnt, 0);
        chk("spur_idle_done", done, 0);
        req = 4'b0100;
        push(2);
        @(negedge clk);
        m_done = 1'b1;
        chk("spur_load_gnt", gnt, 4'b0100);
        chk("spur_load_busy", busy, 1);
        @(negedge clk);
        chk("spur_start_m_start", m_start, 0);
        @(negedge clk);
        m_done = 1'b0;
        chk("spur_start_done", done, 0);
        xfer(6, 1, 0);

        // Reset during WAIT of requester 3
        req = 4'b1000;
        wait_start(cyc);
        chk("abort_start", m_start, 1);
        chk("abort_gnt", gnt, 4'b1000);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_gnt_rst", gnt, 0);
        chk("abort_busy_rst", busy, 0);
        chk("abort_m_din_rst", m_din, 0);
        chk("abort_m_mode_rst", m_mode, 0);
        chk("abort_m_start_rst", m_start, 0);
        chk("abort_done_rst", done, 0);
        chk("abort_err_rst", err, 0);
        req = 4'b1010;
        @(negedge clk);
        @(negedge clk);
        chk("abort_done_held", done, 0);
        rst = 1'b0;
        push(1); push(3);
        xfer(4, 0, 3);
        xfer(3, 0, 3);
        req = 4'b0000;

`ifdef SPI_TIMEOUT_EN
        req = 4'b0001;
        wait_start(cyc);
        chk("tmo_start", m_start, 1);
        cyc = 0;
        while (!done[0] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_cycles", cyc, 64);
        chk("tmo_done", done, 4'b0001);
        chk("tmo_err", err, 1);
        chk("tmo_gnt", gnt, 0);
        req = 4'b0000;
        @(negedge clk);
        chk("tmo_err_single", err, 0);
        chk("tmo_done_single", done, 0);
        @(negedge clk);
        chk("tmo_idle", busy, 0);
`else
        req = 4'b0001;
        wait_start(cyc);
        chk("hold_start", m_start, 1);
        repeat (100) @(negedge clk);
        chk("hold_busy", busy, 1);
        chk("hold_gnt", gnt, 4'b0001);
        chk("hold_done", done, 0);
        chk("hold_err", err, 0);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        chk("hold_done_pulse", done, 4'b0001);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("hold_idle", busy, 0);
`endif
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
